// File: rtl/ex_mem_if.sv
// EX/MEM pipeline boundary bundle: EX-side inputs, MEM-side registered outputs
// and the forwarding compare lines.
interface ex_mem_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic              stall;
  logic              flush;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_result;
  logic              ex_zero;
  logic [DATA_W-1:0] ex_wdata;
  logic [REG_W-1:0]  ex_wreg;
  logic              ex_regwrite;
  logic              ex_memread;
  logic              ex_memwrite;
  logic              ex_memtoreg;
  logic              ex_branch;
  logic [DATA_W-1:0] ex_btarget;
  logic [REG_W-1:0]  fwd_rs;
  logic [REG_W-1:0]  fwd_rt;
  logic              mem_valid;
  logic [DATA_W-1:0] mem_result;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_btarget;
  logic [REG_W-1:0]  mem_wreg;
  logic              mem_regwrite;
  logic              mem_memread;
  logic              mem_memwrite;
  logic              mem_memtoreg;
  logic              mem_pcsrc;
  logic              fwd_a;
  logic              fwd_b;
  logic [31:0]       retired_cnt;

  modport master (
    output stall, flush, ex_valid, ex_result, ex_zero, ex_wdata, ex_wreg,
           ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch,
           ex_btarget, fwd_rs, fwd_rt,
    input  mem_valid, mem_result, mem_wdata, mem_btarget, mem_wreg,
           mem_regwrite, mem_memread, mem_memwrite, mem_memtoreg, mem_pcsrc,
           fwd_a, fwd_b, retired_cnt
  );

  modport slave (
    input  stall, flush, ex_valid, ex_result, ex_zero, ex_wdata, ex_wreg,
           ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch,
           ex_btarget, fwd_rs, fwd_rt,
    output mem_valid, mem_result, mem_wdata, mem_btarget, mem_wreg,
           mem_regwrite, mem_memread, mem_memwrite, mem_memtoreg, mem_pcsrc,
           fwd_a, fwd_b, retired_cnt
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with stall/flush, branch resolution, MEM->EX
// forwarding detection and a retired-instruction counter.
module ex_mem_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic       clk,
  input  logic       rst,
  ex_mem_if.slave    bus
);

  logic              vld_p1;
  logic [DATA_W-1:0] result_p1;
  logic [DATA_W-1:0] wdata_p1;
  logic [DATA_W-1:0] btarget_p1;
  logic [REG_W-1:0]  wreg_p1;
  logic              regwrite_p1;
  logic              memread_p1;
  logic              memwrite_p1;
  logic              memtoreg_p1;
  logic              branch_p1;
  logic              zero_p1;
  logic [31:0]       cnt_p1;

  // EX -> MEM boundary: control bits are qualified by ex_valid so bubbles carry no side effects
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      result_p1   <= '0;
      wdata_p1    <= '0;
      btarget_p1  <= '0;
      wreg_p1     <= '0;
      regwrite_p1 <= 1'b0;
      memread_p1  <= 1'b0;
      memwrite_p1 <= 1'b0;
      memtoreg_p1 <= 1'b0;
      branch_p1   <= 1'b0;
      zero_p1     <= 1'b0;
      cnt_p1      <= '0;
    end else if (bus.flush) begin
      vld_p1      <= 1'b0;
      result_p1   <= '0;
      wdata_p1    <= '0;
      btarget_p1  <= '0;
      wreg_p1     <= '0;
      regwrite_p1 <= 1'b0;
      memread_p1  <= 1'b0;
      memwrite_p1 <= 1'b0;
      memtoreg_p1 <= 1'b0;
      branch_p1   <= 1'b0;
      zero_p1     <= 1'b0;
    end else if (!bus.stall) begin
      vld_p1      <= bus.ex_valid;
      result_p1   <= bus.ex_result;
      wdata_p1    <= bus.ex_wdata;
      btarget_p1  <= bus.ex_btarget;
      wreg_p1     <= bus.ex_wreg;
      regwrite_p1 <= bus.ex_valid & bus.ex_regwrite;
      memread_p1  <= bus.ex_valid & bus.ex_memread;
      memwrite_p1 <= bus.ex_valid & bus.ex_memwrite;
      memtoreg_p1 <= bus.ex_valid & bus.ex_memtoreg;
      branch_p1   <= bus.ex_valid & bus.ex_branch;
      zero_p1     <= bus.ex_zero;
      if (bus.ex_valid)
        cnt_p1 <= cnt_p1 + 32'd1;
    end
  end

  // MEM side: registered copies, branch decision and forwarding compares
  logic fwd_ok;

  assign bus.mem_valid    = vld_p1;
  assign bus.mem_result   = result_p1;
  assign bus.mem_wdata    = wdata_p1;
  assign bus.mem_btarget  = btarget_p1;
  assign bus.mem_wreg     = wreg_p1;
  assign bus.mem_regwrite = regwrite_p1;
  assign bus.mem_memread  = memread_p1;
  assign bus.mem_memwrite = memwrite_p1;
  assign bus.mem_memtoreg = memtoreg_p1;
  assign bus.mem_pcsrc    = vld_p1 & branch_p1 & zero_p1;
  assign bus.retired_cnt  = cnt_p1;

  // Load results are not ready yet and r0 is hardwired, so neither may forward
  assign fwd_ok    = vld_p1 & regwrite_p1 & ~memread_p1 & (wreg_p1 != '0);
  assign bus.fwd_a = fwd_ok & (wreg_p1 == bus.fwd_rs);
  assign bus.fwd_b = fwd_ok & (wreg_p1 == bus.fwd_rt);

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: a reference model pushes expected EX/MEM
// state per driven cycle, which is popped and compared after each clock edge.
module tb_ex_mem_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ex_mem_if #(.DATA_W(32), .REG_W(5)) bus ();

  ex_mem_stage #(.DATA_W(32), .REG_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] result;
    logic [31:0] wdata;
    logic [31:0] btarget;
    logic [4:0]  wreg;
    logic        rw, mr, mw, mt, br, zero;
    logic [31:0] cnt;
  } st_t;

  st_t m;
  st_t q[$];
  int  n_vec = 0;
  int  n_err = 0;

  function automatic st_t zero_state();
    st_t z;
    z.valid = 0; z.result = 0; z.wdata = 0; z.btarget = 0; z.wreg = 0;
    z.rw = 0; z.mr = 0; z.mw = 0; z.mt = 0; z.br = 0; z.zero = 0; z.cnt = 0;
    return z;
  endfunction

  task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag, input st_t e);
    logic ok;
    ok = e.valid & e.rw & ~e.mr & (e.wreg != 5'd0);
    cmp({tag, ".valid"},    32'(bus.mem_valid),    32'(e.valid));
    cmp({tag, ".result"},   bus.mem_result,        e.result);
    cmp({tag, ".wdata"},    bus.mem_wdata,         e.wdata);
    cmp({tag, ".btarget"},  bus.mem_btarget,       e.btarget);
    cmp({tag, ".wreg"},     32'(bus.mem_wreg),     32'(e.wreg));
    cmp({tag, ".ctl"},
        32'({bus.mem_regwrite, bus.mem_memread, bus.mem_memwrite, bus.mem_memtoreg}),
        32'({e.rw, e.mr, e.mw, e.mt}));
    cmp({tag, ".pcsrc"},    32'(bus.mem_pcsrc),    32'(e.valid & e.br & e.zero));
    cmp({tag, ".fwd_a"},    32'(bus.fwd_a),        32'(ok & (e.wreg == bus.fwd_rs)));
    cmp({tag, ".fwd_b"},    32'(bus.fwd_b),        32'(ok & (e.wreg == bus.fwd_rt)));
    cmp({tag, ".cnt"},      bus.retired_cnt,       e.cnt);
  endtask

  // Drive one cycle of EX inputs and push the state the model expects after the edge
  task automatic drive(input logic v, input logic [31:0] res, input logic [31:0] wd,
                       input logic [31:0] bt, input logic [4:0] wr,
                       input logic rw, input logic mr, input logic mw, input logic mt,
                       input logic br, input logic z, input logic st, input logic fl);
    st_t n;
    bus.ex_valid = v;   bus.ex_result = res; bus.ex_wdata = wd; bus.ex_btarget = bt;
    bus.ex_wreg = wr;   bus.ex_regwrite = rw; bus.ex_memread = mr;
    bus.ex_memwrite = mw; bus.ex_memtoreg = mt; bus.ex_branch = br; bus.ex_zero = z;
    bus.stall = st;     bus.flush = fl;
    n = m;
    if (fl) begin
      n = zero_state();
      n.cnt = m.cnt;
    end else if (!st) begin
      n.valid = v; n.result = res; n.wdata = wd; n.btarget = bt; n.wreg = wr;
      n.rw = v & rw; n.mr = v & mr; n.mw = v & mw; n.mt = v & mt; n.br = v & br;
      n.zero = z;
      if (v) n.cnt = m.cnt + 32'd1;
    end
    m = n;
    q.push_back(n);
  endtask

  task automatic tick(input string tag);
    st_t e;
    @(posedge clk);
    #1;
    n_vec++;
    assert (q.size() != 0) else begin
      n_err++;
      $error("FAIL %s.queue observed=empty expected=entry", tag);
    end
    if (q.size() != 0) begin
      e = q.pop_front();
      check_state(tag, e);
    end
  endtask

  task automatic load(input logic [31:0] res, input logic [4:0] wr);
    drive(1, res, ~res, res + 32'd4, wr, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation timeout");
  end

  initial begin
    bus.fwd_rs = 0; bus.fwd_rt = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    m = zero_state();
    q.delete();

    // Reset held: everything zero before any edge
    #2;
    check_state("reset", zero_state());
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic load
    bus.fwd_rs = 5'd1; bus.fwd_rt = 5'd2;
    drive(1, 32'h0000_00A5, 32'h1234_5678, 32'h0, 5'd8, 1, 0, 0, 0, 0, 0, 0, 0);
    tick("load");

    // Branch taken / not taken
    drive(1, 32'h0, 32'h0, 32'h0040_0020, 5'd0, 0, 0, 0, 0, 1, 1, 0, 0);
    tick("br_taken");
    drive(1, 32'h1, 32'h0, 32'h0040_0020, 5'd0, 0, 0, 0, 0, 1, 0, 0, 0);
    tick("br_not");

    // Bubble with all control bits set: must be captured as zero
    drive(0, 32'hDEAD_BEEF, 32'h5, 32'h0040_0100, 5'd7, 1, 1, 1, 1, 1, 1, 0, 0);
    tick("bubble");

    // Forwarding to both operands, then rs moves away combinationally
    bus.fwd_rs = 5'd9; bus.fwd_rt = 5'd9;
    load(32'h0000_0099, 5'd9);
    tick("fwd_hit");
    bus.fwd_rs = 5'd3;
    #1;
    cmp("fwd_comb.a", 32'(bus.fwd_a), 32'd0);
    cmp("fwd_comb.b", 32'(bus.fwd_b), 32'd1);
    bus.fwd_rs = 5'd9;

    // r0 destination and load in MEM never forward
    bus.fwd_rs = 5'd0; bus.fwd_rt = 5'd0;
    load(32'h0000_0077, 5'd0);
    tick("fwd_r0");
    bus.fwd_rs = 5'd9; bus.fwd_rt = 5'd9;
    drive(1, 32'h1000_0000, 32'h0, 32'h0, 5'd9, 1, 1, 0, 1, 0, 0, 0, 0);
    tick("fwd_load");

    // Stall three cycles with changing inputs
    load(32'h0000_0055, 5'd9);
    tick("pre_stall");
    for (int i = 0; i < 3; i++) begin
      drive(1, $urandom, $urandom, $urandom, 5'($urandom), 1, 1, 1, 1, 1, 1, 1, 0);
      tick("stall");
    end

    // Flush wins over stall
    drive(1, 32'hFFFF_0000, 32'h1, 32'h2, 5'd12, 1, 0, 1, 1, 1, 1, 1, 1);
    tick("flush_stall");

    // Randomised loads
    for (int i = 0; i < 6; i++) begin
      bus.fwd_rs = 5'($urandom); bus.fwd_rt = 5'($urandom);
      drive(1'($urandom), $urandom, $urandom, $urandom, 5'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), 0, 0);
      tick("rand");
    end

    // Reset then resume, count up to five, and reset asynchronously mid-stall
    rst = 1'b1;
    #1;
    m = zero_state();
    q.delete();
    check_state("rst_sync", m);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.fwd_rs = 5'd4; bus.fwd_rt = 5'd4;
    for (int i = 0; i < 5; i++) begin
      load(32'h100 + 32'(i), 5'd4);
      tick("count");
    end
    drive(1, 32'h0, 32'h0, 32'h0, 5'd4, 1, 0, 0, 0, 0, 0, 1, 0);
    #2;
    rst = 1'b1;
    #1;
    m = zero_state();
    q.delete();
    check_state("rst_async", m);
    @(posedge clk); #1;
    rst = 1'b0;
    load(32'h0000_0321, 5'd6);
    tick("resume");

    // Counter wrap
    force dut.cnt_p1 = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_p1;
    m.cnt = 32'hFFFF_FFFF;
    cmp("preload", bus.retired_cnt, 32'hFFFF_FFFF);
    load(32'h0000_0001, 5'd6);
    tick("wrap");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 Parameter: DATA_W, 32, datapath width of result, store data and branch target.
REQ-002 Parameter: REG_W, 5, register-index width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 stall  input  1  hold all EX/MEM state this cycle.
REQ-006 flush  input  1  replace the EX/MEM contents with a bubble this cycle.
REQ-007 ex_valid  input  1  EX stage holds a real instruction.
REQ-008 ex_result  input  DATA_W  EX-stage ALU/shifter result.
REQ-009 ex_zero  input  1  EX-stage ALU zero flag.
REQ-010 ex_wdata  input  DATA_W  store data (rt value).
REQ-011 ex_wreg  input  REG_W  destination register index.
REQ-012 ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch  input  1 each  EX control bits.
REQ-013 ex_btarget  input  DATA_W  computed branch target.
REQ-014 fwd_rs, fwd_rt  input  REG_W each  source indices of the instruction currently in EX.
REQ-015 mem_valid  output  1  registered valid bit.
REQ-016 mem_result, mem_wdata, mem_btarget  output  DATA_W each  registered copies.
REQ-017 mem_wreg  output  REG_W  registered destination index.
REQ-018 mem_regwrite, mem_memread, mem_memwrite, mem_memtoreg  output  1 each  registered control bits.
REQ-019 mem_pcsrc  output  1  branch taken, resolved from registered state.
REQ-020 fwd_a, fwd_b  output  1 each  forward mem_result to the EX A/B operand.
REQ-021 retired_cnt  output  32  count of valid instructions accepted into EX/MEM.

Function
REQ-022 Update priority per edge: rst > flush > stall > load.
REQ-023 Load (no stall/flush): all mem_* registers take their ex_* inputs, mem_valid <= ex_valid, and the zero flag is captured internally; latency one cycle.
REQ-024 Stall (flush=0): every register, including retired_cnt, holds its value.
REQ-025 Flush: mem_valid and all control bits <= 0; data fields and mem_wreg <= 0; flush wins when asserted together with stall.
REQ-026 Qualification: when ex_valid=0 on a load, all control bits are captured as 0 regardless of the ex_* control values.
REQ-027 mem_pcsrc = mem_valid AND captured branch bit AND captured zero; combinational from registers only.
REQ-028 fwd_a = mem_valid AND mem_regwrite AND NOT mem_memread AND mem_wreg!=0 AND mem_wreg==fwd_rs; fwd_b is identical with fwd_rt.
REQ-029 Register 0 is never forwarded, even when mem_regwrite=1.
REQ-030 Loads in MEM are never forwarded from this stage, because the load data is not yet available.
REQ-031 retired_cnt increments by 1 on each load edge with ex_valid=1; it does not increment on stall, flush or bubble, and wraps from 0xFFFFFFFF to 0.
REQ-032 No combinational path exists from any ex_* input to any output except through the registers; fwd_rs and fwd_rt reach fwd_a and fwd_b combinationally.

Reset
REQ-033 While rst=1, all outputs are 0 immediately, independent of clk: mem_valid, all data fields, mem_wreg, all control bits, mem_pcsrc, fwd_a, fwd_b and retired_cnt.
REQ-034 On the first rising edge after rst deasserts, normal loading resumes; rst asserted mid-stall or mid-flush clears the state identically.

Verification
REQ-035 Load: ex_valid=1, ex_result=0x0000_00A5, ex_wreg=8, ex_regwrite=1 -> next cycle mem_result=0xA5, mem_wreg=8, mem_regwrite=1, retired_cnt=1.
REQ-036 Branch: ex_branch=1, ex_zero=1, ex_btarget=0x0040_0020 -> next cycle mem_pcsrc=1, mem_btarget=0x0040_0020; same with ex_zero=0 -> mem_pcsrc=0.
REQ-037 Stall and flush: stall=1 for 3 cycles with changing inputs -> outputs unchanged; stall=1 with flush=1 -> mem_valid=0, all control bits 0, retired_cnt unchanged.
REQ-038 Forwarding: mem_wreg=9, mem_regwrite=1, fwd_rs=9, fwd_rt=9 -> fwd_a=fwd_b=1; the same case with mem_wreg=0 or mem_memread=1 -> fwd_a=fwd_b=0.
REQ-039 Async reset: assert rst between clock edges while mem_valid=1 and retired_cnt=5 -> all outputs 0 before the next edge.
REQ-040 Wrap: preload retired_cnt to 0xFFFFFFFF via 2^32-1 valid loads (or a force), then one more valid load -> retired_cnt=0.
